program_loader: RTL and testbench

- Upstream stage of the CPU core. Receives the program image as a byte stream from the SD-card reader and writes it byte-by-byte into SDRAM from address 0.
- Scans the image for the code-section marker byte and reports code_section_start_address (marker address + 1) to the core.
- Signals completion or error, so the core leaves its load state only after a clean image is in memory.

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader_marker_scanner.sv | 51 +++++
 rtl/program_loader.sv | 160 ++++++++++++++++
 tb/tb_program_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared encodings for the program loader stage.
// State, error codes and default parameters live here.
package program_loader_pkg;

   typedef enum logic [2:0] {
      LOADER_STATE_IDLE   = 3'd0,
      LOADER_STATE_ACCEPT = 3'd1,
      LOADER_STATE_WRITE  = 3'd2,
      LOADER_STATE_FINISH = 3'd3,
      LOADER_STATE_FAULT  = 3'd4
   } loader_state_e;

   typedef enum logic [1:0] {
      LOADER_ERR_NONE       = 2'd0,
      LOADER_ERR_NO_MARKER  = 2'd1,
      LOADER_ERR_OVERFLOW   = 2'd2,
      LOADER_ERR_EMPTY_CODE = 2'd3
   } loader_err_e;

   localparam int          LOADER_ADDR_WIDTH = 23;
   localparam int          LOADER_MEM_BYTES  = 8000000;
   localparam logic [7:0]  LOADER_CODE_MARKER = 8'd14;

endpackage

// File: rtl/program_loader_marker_scanner.sv
// Watches accepted stream bytes for the code marker.
// Latches the address after the first marker only.
module code_marker_scanner
   import program_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH  = LOADER_ADDR_WIDTH,
   parameter logic [7:0] CODE_MARKER = LOADER_CODE_MARKER
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                accept,
   input  logic [7:0]          in_data,
   input  logic [ADDR_WIDTH:0] byte_count,
   output logic [31:0]         code_start_addr,
   output logic                code_start_valid
);

   localparam logic [ADDR_WIDTH:0] ONE = 1;

   logic [ADDR_WIDTH:0] addr_q, addr_d;
   logic                valid_q, valid_d;

   // first marker wins; clear on a new load
   always_comb begin
      addr_d  = addr_q;
      valid_d = valid_q;
      if (clear) begin
         addr_d  = '0;
         valid_d = 1'b0;
      end else if (accept && !valid_q && in_data == CODE_MARKER) begin
         addr_d  = byte_count + ONE;
         valid_d = 1'b1;
      end
   end

   // marker registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         valid_q <= valid_d;
      end
   end

   assign code_start_addr  = {{(31 - ADDR_WIDTH){1'b0}}, addr_q};
   assign code_start_valid = valid_q;

endmodule

// File: rtl/program_loader.sv
// Streams the program image into SDRAM from address 0.
// Reports the code section start and load status.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH  = LOADER_ADDR_WIDTH,
   parameter int         MEM_BYTES   = LOADER_MEM_BYTES,
   parameter logic [7:0] CODE_MARKER = LOADER_CODE_MARKER
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [7:0]            mem_wr_data,
   input  logic                  mem_wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            error,
   output logic [31:0]           code_start_addr,
   output logic                  code_start_valid,
   output logic [ADDR_WIDTH:0]   byte_count
);

   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);
   localparam logic [ADDR_WIDTH:0] ONE       = 1;

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            data_q, data_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   loader_err_e           error_q, error_d;

   logic                  full;
   logic                  accept;
   logic                  restart;
   logic [ADDR_WIDTH:0]   count_inc;
   logic                  empty_code;

   assign full      = (count_q == MEM_LIMIT);
   assign in_ready  = (state_q == LOADER_STATE_ACCEPT) && !full;
   assign accept    = in_valid && in_ready;
   assign restart   = start && (state_q == LOADER_STATE_IDLE ||
                                state_q == LOADER_STATE_FINISH ||
                                state_q == LOADER_STATE_FAULT);
   assign count_inc = count_q + ONE;

   code_marker_scanner #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .CODE_MARKER (CODE_MARKER)
   ) u_scanner (
      .clk              (clk),
      .reset_n          (reset_n),
      .clear            (restart),
      .accept           (accept),
      .in_data          (in_data),
      .byte_count       (count_q),
      .code_start_addr  (code_start_addr),
      .code_start_valid (code_start_valid)
   );

   // marker on the final byte leaves no code behind it
   assign empty_code = (code_start_addr == {{(31 - ADDR_WIDTH){1'b0}}, count_inc});

   // next-state, write capture and status updates
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = done_q;
      error_d = error_q;
      unique case (state_q)
         LOADER_STATE_IDLE,
         LOADER_STATE_FINISH,
         LOADER_STATE_FAULT: begin
            if (start) begin
               state_d = LOADER_STATE_ACCEPT;
               count_d = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               error_d = LOADER_ERR_NONE;
            end
         end
         LOADER_STATE_ACCEPT: begin
            if (accept) begin
               state_d = LOADER_STATE_WRITE;
               addr_d  = count_q[ADDR_WIDTH-1:0];
               data_d  = in_data;
               last_d  = in_last;
            end else if (in_valid && full) begin
               state_d = LOADER_STATE_FAULT;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               error_d = LOADER_ERR_OVERFLOW;
            end
         end
         LOADER_STATE_WRITE: begin
            if (mem_wr_ready) begin
               count_d = count_inc;
               if (last_q) begin
                  state_d = LOADER_STATE_FINISH;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  if (!code_start_valid)
                     error_d = LOADER_ERR_NO_MARKER;
                  else if (empty_code)
                     error_d = LOADER_ERR_EMPTY_CODE;
                  else
                     error_d = LOADER_ERR_NONE;
               end else begin
                  state_d = LOADER_STATE_ACCEPT;
               end
            end
         end
         default: state_d = LOADER_STATE_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= LOADER_STATE_IDLE;
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= LOADER_ERR_NONE;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign mem_wr_en   = (state_q == LOADER_STATE_WRITE);
   assign mem_wr_addr = addr_q;
   assign mem_wr_data = data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign byte_count  = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Two instances: default size and a 4-byte memory.
module tb_program_loader;

   localparam int AW = 23;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          mem_wr_ready = 1'b1;
   logic          sel = 1'b0;

   logic          a_in_ready, b_in_ready;
   logic          a_wr_en, b_wr_en;
   logic [AW-1:0] a_wr_addr, b_wr_addr;
   logic [7:0]    a_wr_data, b_wr_data;
   logic          a_busy, b_busy;
   logic          a_done, b_done;
   logic [1:0]    a_error, b_error;
   logic [31:0]   a_csa, b_csa;
   logic          a_csv, b_csv;
   logic [AW:0]   a_cnt, b_cnt;

   logic          in_ready, mem_wr_en, busy, done, code_start_valid;
   logic [AW-1:0] mem_wr_addr;
   logic [7:0]    mem_wr_data;
   logic [1:0]    error;
   logic [31:0]   code_start_addr;
   logic [AW:0]   byte_count;

   int vectors = 0;
   int miscompares = 0;
   int wr_count = 0;
   int base = 0;
   int addr_errs = 0;
   int snap;
   logic [7:0] mem [0:15];

   always #5 clk = ~clk;

   program_loader u_big (
      .clk(clk), .reset_n(reset_n), .start(start && !sel),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(a_in_ready), .mem_wr_en(a_wr_en),
      .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data),
      .mem_wr_ready(mem_wr_ready), .busy(a_busy), .done(a_done),
      .error(a_error), .code_start_addr(a_csa),
      .code_start_valid(a_csv), .byte_count(a_cnt)
   );

   program_loader #(.MEM_BYTES(4)) u_small (
      .clk(clk), .reset_n(reset_n), .start(start && sel),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(b_in_ready), .mem_wr_en(b_wr_en),
      .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
      .mem_wr_ready(mem_wr_ready), .busy(b_busy), .done(b_done),
      .error(b_error), .code_start_addr(b_csa),
      .code_start_valid(b_csv), .byte_count(b_cnt)
   );

   always_comb begin
      in_ready         = sel ? b_in_ready : a_in_ready;
      mem_wr_en        = sel ? b_wr_en    : a_wr_en;
      mem_wr_addr      = sel ? b_wr_addr  : a_wr_addr;
      mem_wr_data      = sel ? b_wr_data  : a_wr_data;
      busy             = sel ? b_busy     : a_busy;
      done             = sel ? b_done     : a_done;
      error            = sel ? b_error    : a_error;
      code_start_addr  = sel ? b_csa      : a_csa;
      code_start_valid = sel ? b_csv      : a_csv;
      byte_count       = sel ? b_cnt      : a_cnt;
   end

   // SDRAM model: records completed writes
   always @(posedge clk) begin
      if (mem_wr_en && mem_wr_ready) begin
         if (32'(mem_wr_addr) != 32'(wr_count - base))
            addr_errs = addr_errs + 1;
         mem[mem_wr_addr[3:0]] = mem_wr_data;
         wr_count = wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_load();
      base = wr_count;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n = 0;
      in_data = d;
      in_valid = 1'b1;
      in_last = l;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", {31'b0, n < 100}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", {31'b0, n < 100}, 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"},
            {26'b0, in_ready, mem_wr_en, busy, done, code_start_valid,
             1'b0}, 32'd0);
      check({tag, "_err"}, {30'b0, error}, 32'd0);
      check({tag, "_csa"}, code_start_addr, 32'd0);
      check({tag, "_cnt"}, 32'(byte_count), 32'd0);
      check({tag, "_wa"}, 32'(mem_wr_addr), 32'd0);
      check({tag, "_wd"}, {24'b0, mem_wr_data}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // image with marker at address 2
      start_load();
      check("start_busy", {30'b0, busy, in_ready}, 32'd3);
      send_byte(8'h00, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h0E, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_ignored", 32'(byte_count), 32'd3);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b1);
      wait_done();
      check("a_writes", wr_count - base, 32'd6);
      check("a_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h00050E01);
      check("a_mem_hi", {16'b0, mem[4], mem[5]}, 32'h00000203);
      check("a_csa", code_start_addr, 32'd3);
      check("a_stat", {28'b0, code_start_valid, done, error}, 32'b1100);
      check("a_busy", {31'b0, busy}, 32'd0);
      check("a_cnt", 32'(byte_count), 32'd6);
      repeat (3) @(negedge clk);
      check("a_done_hold", {31'b0, done}, 32'd1);

      // two markers: first one wins
      start_load();
      check("b_cleared", {code_start_valid, done, error, 28'(byte_count)},
            32'd0);
      send_byte(8'h0E, 1'b0);
      send_byte(8'h07, 1'b0);
      send_byte(8'h0E, 1'b0);
      send_byte(8'h09, 1'b1);
      wait_done();
      check("b_csa", code_start_addr, 32'd1);
      check("b_mem2", {24'b0, mem[2]}, 32'h0E);
      check("b_err", {30'b0, error}, 32'd0);

      // no marker
      start_load();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b1);
      wait_done();
      check("c_stat", {29'b0, code_start_valid, error}, 32'd1);
      check("c_writes", wr_count - base, 32'd3);

      // write stall on the second byte
      start_load();
      send_byte(8'h00, 1'b0);
      @(negedge clk);
      mem_wr_ready = 1'b0;
      send_byte(8'h0E, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("d_stall",
               {mem_wr_en, in_ready, 6'b0, mem_wr_data, 16'(mem_wr_addr)},
               {1'b1, 1'b0, 6'b0, 8'h0E, 16'd1});
         @(negedge clk);
      end
      mem_wr_ready = 1'b1;
      send_byte(8'h04, 1'b1);
      wait_done();
      check("d_stat", {code_start_valid, error, 29'(byte_count)},
            {1'b1, 2'd0, 29'd3});
      check("d_csa", code_start_addr, 32'd2);
      check("d_mem1", {24'b0, mem[1]}, 32'h0E);

      // 4-byte memory: fifth byte overflows
      sel = 1'b1;
      @(negedge clk);
      start_load();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      in_data = 8'h05;
      in_valid = 1'b1;
      wait_done();
      check("e_stat", {29'b0, busy, error}, 32'd2);
      check("e_ready", {31'b0, in_ready}, 32'd0);
      check("e_cnt", 32'(byte_count), 32'd4);
      @(negedge clk);
      in_valid = 1'b0;
      check("e_writes", wr_count - base, 32'd4);
      check("e_ready2", {30'b0, in_ready, done}, 32'd1);

      // 4-byte memory: last byte at final address is legal
      start_load();
      send_byte(8'h01, 1'b0);
      send_byte(8'h0E, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b1);
      wait_done();
      check("f_stat", {30'b0, error}, 32'd0);
      check("f_csa", code_start_addr, 32'd2);
      check("f_cnt", 32'(byte_count), 32'd4);
      sel = 1'b0;
      @(negedge clk);

      // reset in the middle of a load
      start_load();
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      check_zero("g_rst");
      snap = wr_count;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("g_no_wr", wr_count - snap, 32'd0);
      start_load();
      send_byte(8'h0E, 1'b1);
      wait_done();
      check("g_stat", {28'b0, code_start_valid, done, error}, 32'b1111);
      check("g_mem0", {24'b0, mem[0]}, 32'h0E);
      check("g_cnt", 32'(byte_count), 32'd1);
      check("addr_seq", addr_errs, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
